// File: rtl/ac_dc_probe_pkg.sv
// ac_dc_probe_pkg: shared state type, accumulator width helpers and window length.
package ac_dc_probe_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  function automatic int dc_w(input int dw, input int log2n);
    return dw + log2n;
  endfunction
  function automatic int iq_w(input int dw, input int rw, input int log2n);
    return dw + rw + log2n;
  endfunction
  function automatic longint win_len(input int log2n);
    return longint'(1) << log2n;
  endfunction
endpackage

// File: rtl/ac_dc_probe_mac.sv
// ac_dc_probe_mac: one signed multiply-accumulate lane.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : clear the sum
//   i_en     : add i_data*i_ref this cycle
//   i_data   : signed sample
//   i_ref    : signed reference
//   o_sum    : registered running sum
//   o_next   : sum including the current product, used to capture the record
module ac_dc_probe_mac #(
  parameter int DW = 16,
  parameter int RW = 16,
  parameter int AW = 42
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_data,
  input  logic signed [RW-1:0] i_ref,
  output logic signed [AW-1:0] o_sum,
  output logic signed [AW-1:0] o_next
);
  logic signed [DW+RW-1:0] w_prod;
  logic signed [AW-1:0]    r_sum;
  assign w_prod = i_data * i_ref;
  assign o_next = r_sum + {{(AW-DW-RW){w_prod[DW+RW-1]}}, w_prod};
  assign o_sum  = r_sum;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_sum <= '0;
    else if (i_en) r_sum <= o_next;
  end
endmodule

// File: rtl/ac_dc_probe.sv
// ac_dc_probe: windowed DC mean and I/Q correlation of a sample stream.
//   start/busy         : window request (honoured only in IDLE) / ACC or DONE
//   s_valid/s_ready    : sample handshake; s_data sample, s_cos/s_sin reference
//   m_valid/m_ready    : result handshake; m_dc mean, m_i/m_q raw correlation sums
//   PROBE_IQ_EN        : when defined, builds the I/Q lanes; otherwise m_i/m_q are 0
module ac_dc_probe
  import ac_dc_probe_pkg::*;
#(
  parameter int DW    = 16,
  parameter int RW    = 16,
  parameter int LOG2N = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [DW-1:0]          s_data,
  input  logic signed [RW-1:0]          s_cos,
  input  logic signed [RW-1:0]          s_sin,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [DW-1:0]          m_dc,
  output logic signed [DW+RW+LOG2N-1:0] m_i,
  output logic signed [DW+RW+LOG2N-1:0] m_q
);
  localparam int DCW = dc_w(DW, LOG2N);
  localparam int IQW = iq_w(DW, RW, LOG2N);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(win_len(LOG2N) - 1);
  state_t                r_state, w_state_nxt;
  logic [LOG2N-1:0]      r_cnt;
  logic signed [DCW-1:0] r_sum_dc, w_dc_next;
  logic signed [DW-1:0]  r_m_dc, w_dc_mean;
  logic                  w_clr, w_acc, w_last, w_unused;
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = r_state == ACC;
    busy        = r_state != IDLE;
    m_valid     = r_state == DONE;
    w_clr       = r_state == IDLE && start;
    w_acc       = s_valid && s_ready;
    w_last      = w_acc && r_cnt == LAST;
    if (w_clr) w_state_nxt = ACC;
    if (w_last) w_state_nxt = DONE;
    if (m_valid && m_ready) w_state_nxt = IDLE;
  end
  assign w_dc_next = r_sum_dc + {{LOG2N{s_data[DW-1]}}, s_data};
  // Bits [LOG2N +: DW] of the sum are exactly sum >>> LOG2N (floor), already in DW bits.
  assign w_dc_mean = w_dc_next[LOG2N +: DW];
  assign m_dc      = r_m_dc;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sum_dc <= '0;
      r_m_dc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_cnt    <= '0;
        r_sum_dc <= '0;
      end else if (w_acc) begin
        r_cnt    <= r_cnt + 1'b1;
        r_sum_dc <= w_dc_next;
      end
      if (w_last) r_m_dc <= w_dc_mean;
    end
  end
`ifdef PROBE_IQ_EN
  logic signed [IQW-1:0] w_i_sum, w_i_next, w_q_sum, w_q_next, r_m_i, r_m_q;
  ac_dc_probe_mac #(.DW(DW), .RW(RW), .AW(IQW)) u_mac_i (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_acc),
    .i_data(s_data), .i_ref(s_cos), .o_sum(w_i_sum), .o_next(w_i_next)
  );
  ac_dc_probe_mac #(.DW(DW), .RW(RW), .AW(IQW)) u_mac_q (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_acc),
    .i_data(s_data), .i_ref(s_sin), .o_sum(w_q_sum), .o_next(w_q_next)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_i <= '0;
      r_m_q <= '0;
    end else if (w_last) begin
      r_m_i <= w_i_next;
      r_m_q <= w_q_next;
    end
  end
  assign m_i      = r_m_i;
  assign m_q      = r_m_q;
  assign w_unused = ^{w_i_sum, w_q_sum};
`else
  assign m_i      = '0;
  assign m_q      = '0;
  assign w_unused = ^{s_cos, s_sin};
`endif
endmodule

// File: tb/tb_ac_dc_probe.sv
// tb_ac_dc_probe: scoreboard bench for ac_dc_probe with a 16-sample window.
module tb_ac_dc_probe;
  localparam int DW = 16, RW = 16, L = 4, IW = DW + RW + L, N = 16;
  logic clk = 0, rst = 1, start = 0, s_valid = 0, m_ready = 1;
  logic busy, s_ready, m_valid;
  logic signed [DW-1:0] s_data = 0, m_dc;
  logic signed [RW-1:0] s_cos = 0, s_sin = 0;
  logic signed [IW-1:0] m_i, m_q;
  typedef struct {
    logic signed [DW-1:0] dc;
    logic signed [IW-1:0] i;
    logic signed [IW-1:0] q;
    int lat;
  } rec_t;
  rec_t sbq[$];
  int total = 0, bad = 0;
  logic signed [DW-1:0] vd[N], vc[N], vs[N];
  time t_start = 0, t_rise = 0;
  always #5 clk = ~clk;
  ac_dc_probe #(.DW(DW), .RW(RW), .LOG2N(L)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_cos(s_cos), .s_sin(s_sin),
    .m_valid(m_valid), .m_ready(m_ready), .m_dc(m_dc), .m_i(m_i), .m_q(m_q)
  );
  function automatic logic signed [IW-1:0] iqx(input logic signed [IW-1:0] v);
`ifdef PROBE_IQ_EN
    return v;
`else
    return '0;
`endif
  endfunction
  task automatic chk(input string nm, input logic signed [63:0] a, input logic signed [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, a, e, $time);
    end
  endtask
  task automatic expect_rec(input logic signed [DW-1:0] dc, input logic signed [IW-1:0] i,
                            input logic signed [IW-1:0] q, input int lat);
    rec_t r;
    r.dc = dc; r.i = iqx(i); r.q = iqx(q); r.lat = lat;
    sbq.push_back(r);
  endtask
  // Monitor: counts accepts, checks record stability while held, pops on each handshake.
  int nacc = 0;
  logic pv = 0;
  logic signed [DW-1:0] hdc;
  logic signed [IW-1:0] hi, hq;
  always @(negedge clk) begin
    if (rst) begin
      nacc = 0;
      pv = 0;
    end else begin
      if (s_valid && s_ready) nacc++;
      if (m_valid && !pv) t_rise = $time;
      if (m_valid && pv) begin
        chk("hold_dc", m_dc, hdc);
        chk("hold_i", m_i, hi);
        chk("hold_q", m_q, hq);
      end
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_record got=1 want=0 at %0t", $time);
        end else begin
          rec_t e;
          e = sbq.pop_front();
          chk("m_dc", m_dc, e.dc);
          chk("m_i", m_i, e.i);
          chk("m_q", m_q, e.q);
          chk("accepts", nacc, N);
          if (e.lat > 0) chk("latency", longint'((t_rise - 5 - t_start) / 10), e.lat);
        end
        nacc = 0;
      end
      pv = m_valid; hdc = m_dc; hi = m_i; hq = m_q;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    t_start = $time - 1;
    start = 1;
    tick();
    start = 0;
    chk("ready_after_start", s_ready, 1);
  endtask
  task automatic feed(input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      int w;
      s_valid = 1; s_data = vd[k]; s_cos = vc[k]; s_sin = vs[k];
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!s_ready && w < 50);
      if (!s_ready) chk("ready_timeout", s_ready, 1);
      tick();
      if (gap) begin
        s_valid = 0; s_data = 16'sh7fff; s_cos = 16'sh7fff; s_sin = 16'sh7fff;
        tick();
      end
    end
    s_valid = 0;
  endtask
  task automatic wait_valid();
    int w;
    w = 0;
    while (!m_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!m_valid) chk("valid_timeout", m_valid, 1);
  endtask
  task automatic finish_win();
    int w;
    wait_valid();
    w = 0;
    while (m_valid && w < 10) begin
      tick();
      w++;
    end
    chk("idle_busy", busy, 0);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_dc"}, m_dc, 0);
    chk({tag, "_m_i"}, m_i, 0);
    chk({tag, "_m_q"}, m_q, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    rst = 0;
    tick();
    check_zero("reset");
    for (int k = 0; k < N; k++) begin vd[k] = 100; vc[k] = 0; vs[k] = 0; end
    expect_rec(100, 0, 0, 17);
    do_start(); feed(N, 0); finish_win();
    for (int k = 0; k < N; k++) begin
      vd[k] = (k % 2) ? -16'sd1000 : 16'sd1000;
      vc[k] = (k % 2) ? -16'sd32767 : 16'sd32767;
      vs[k] = 0;
    end
    expect_rec(0, 36'sd524272000, 0, 17);
    do_start(); feed(N, 0); finish_win();
    for (int k = 0; k < N; k++) begin vd[k] = -16'sd32768; vc[k] = 16'sd32767; vs[k] = -16'sd32768; end
    expect_rec(-16'sd32768, -36'sd17179344896, 36'sd17179869184, 17);
    do_start(); feed(N, 0); finish_win();
    for (int k = 0; k < N; k++) begin vd[k] = (k == N - 1) ? -16'sd2 : -16'sd1; vc[k] = 1; vs[k] = -1; end
    expect_rec(-2, -36'sd17, 36'sd17, 17);
    do_start(); feed(N, 0); finish_win();
    for (int k = 0; k < N; k++) begin vd[k] = 16'(k * 10); vc[k] = 2; vs[k] = -1; end
    expect_rec(75, 36'sd2400, -36'sd1200, 0);
    m_ready = 0;
    do_start(); feed(N, 1); wait_valid();
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      tick();
    end
    start = 0;
    chk("held_valid", m_valid, 1);
    m_ready = 1; start = 1;
    tick();
    start = 0;
    chk("hs_m_valid", m_valid, 0);
    chk("hs_busy", busy, 0);
    chk("hs_s_ready", s_ready, 0);
    tick();
    chk("start_on_hs_ignored", busy, 0);
    for (int k = 0; k < N; k++) begin vd[k] = 7000; vc[k] = 7; vs[k] = 7; end
    do_start(); feed(5, 0);
    rst = 1;
    tick();
    rst = 0;
    check_zero("midrst");
    for (int k = 0; k < N; k++) begin vd[k] = 3; vc[k] = 5; vs[k] = 0; end
    expect_rec(3, 36'sd240, 0, 17);
    do_start(); feed(N, 0); finish_win();
    repeat (3) tick();
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
